idex_stage: RTL

- ID/EX pipeline register of the 5-stage RV32I core, directly upstream of the forwarding unit.
- Supplies ex_rs1, ex_rs2, ex_rd and ex_reg_write to the forwarding unit and the EX operand muxes.
- Detects load-use hazards, inserts bubbles, honours branch flush and global memory stall.
- Applies a WB-to-ID register-file bypass when latching operands, and keeps bubble/flush performance counters.

---
 rtl/idex_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/idex_stage.sv
// ID/EX pipeline register: load-use hazard detection, bubble/flush insertion,
// global memory-stall hold, WB-to-ID register-file bypass and saturating event counters.
module idex_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_flush,
    input  logic              mem_stall,
    output logic              stall_if_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rdata1,
    output logic [XLEN-1:0]   ex_rdata2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rdata1;
        logic [XLEN-1:0]   rdata2;
        logic [XLEN-1:0]   imm;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [CTRL_W-1:0] ctrl;
        logic              reg_write;
        logic              mem_read;
    } ex_slot_t;

    ex_slot_t         ex_q, ex_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard_c;
    logic wb_live_c;
    logic wb_hit_id1_c, wb_hit_id2_c, wb_hit_ex1_c, wb_hit_ex2_c;

    // Load in EX whose result an ID source needs before it exists.
    always_comb begin
        hazard_c = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0)
                   && id_valid
                   && ((id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_q.rd)));
    end

    // x0 is never bypassed.
    always_comb begin
        wb_live_c    = wb_reg_write && (wb_rd != '0);
        wb_hit_id1_c = wb_live_c && (wb_rd == id_rs1);
        wb_hit_id2_c = wb_live_c && (wb_rd == id_rs2);
        wb_hit_ex1_c = wb_live_c && (wb_rd == ex_q.rs1);
        wb_hit_ex2_c = wb_live_c && (wb_rd == ex_q.rs2);
    end

    assign stall_if_id = mem_stall | (hazard_c & ~ex_flush);

    // Priority: hold, flush, load-use bubble, advance.
    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (mem_stall) begin
            if (wb_hit_ex1_c) ex_d.rdata1 = wb_data;
            if (wb_hit_ex2_c) ex_d.rdata2 = wb_data;
        end else if (ex_flush) begin
            ex_d = '0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (hazard_c) begin
            ex_d = '0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else if (id_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.pc        = id_pc;
            ex_d.rdata1    = wb_hit_id1_c ? wb_data : id_rdata1;
            ex_d.rdata2    = wb_hit_id2_c ? wb_data : id_rdata2;
            ex_d.imm       = id_imm;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.ctrl      = id_ctrl;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end else begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rdata1    = ex_q.rdata1;
    assign ex_rdata2    = ex_q.rdata2;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1       = ex_q.rs1;
    assign ex_rs2       = ex_q.rs2;
    assign ex_rd        = ex_q.rd;
    assign ex_ctrl      = ex_q.ctrl;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign bubble_cnt   = bubble_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
